// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding and prescaler sizing for multi_delay_timer
package timer_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  // Smallest width able to hold period-1 (never below 1 bit).
  function automatic int tick_w_for(input int period);
    int w;
    w = 1;
    for (int k = 1; k < 32; k++) begin
      if ((64'd1 << w) < 64'(period)) w = k + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running tick generator shared by all timer channels
module tick_prescaler #(
  parameter int TICK_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [TICK_W-1:0] period,
  output logic              tick
);

  logic [TICK_W-1:0] pcnt;
  logic              last;

  assign last = (pcnt == period - 1'b1);
  assign tick = enable && last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
    end else if (enable) begin
      pcnt <= last ? '0 : pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/multi_delay_timer.sv
// rtl/multi_delay_timer.sv - NUM_CH one-shot/periodic down-counters on a shared tick
module multi_delay_timer
  import timer_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DELAY_W     = 8,
  parameter int TICK_PERIOD = 500000,
  parameter int TICK_W      = tick_w_for(TICK_PERIOD)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_CH-1:0]         start,
  input  logic [NUM_CH-1:0]         periodic,
  input  logic [NUM_CH-1:0]         abort,
  input  logic [NUM_CH*DELAY_W-1:0] delay,
  output logic [NUM_CH-1:0]         done,
  output logic [NUM_CH-1:0]         done_pulse,
  output logic                      busy,
  output logic [NUM_CH*DELAY_W-1:0] remaining
);

  localparam logic [TICK_W-1:0] PERIOD = TICK_W'(TICK_PERIOD);

  logic              tick;
  logic [NUM_CH-1:0] running;

  tick_prescaler #(.TICK_W(TICK_W)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .period (PERIOD),
    .tick   (tick)
  );

  assign busy = |running;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic               state;
    logic               mode;
    logic [DELAY_W-1:0] cnt;
    logic [DELAY_W-1:0] reload;
    logic               done_q;
    logic               pulse_q;
    logic [DELAY_W-1:0] dly;

    assign dly = delay[i*DELAY_W +: DELAY_W];

    // abort beats start beats tick; cnt==1 on a tick is the expiry point.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state   <= ST_IDLE;
        mode    <= 1'b0;
        cnt     <= '0;
        reload  <= '0;
        done_q  <= 1'b1;
        pulse_q <= 1'b0;
      end else begin
        pulse_q <= 1'b0;
        if (abort[i]) begin
          state  <= ST_IDLE;
          cnt    <= '0;
          done_q <= 1'b1;
        end else if (start[i]) begin
          if (dly != '0) begin
            state  <= ST_RUN;
            mode   <= periodic[i];
            cnt    <= dly;
            reload <= dly;
            done_q <= 1'b0;
          end else begin
            state   <= ST_IDLE;
            cnt     <= '0;
            done_q  <= 1'b1;
            pulse_q <= 1'b1;
          end
        end else if (state == ST_RUN && tick) begin
          if (cnt > DELAY_W'(1)) begin
            cnt <= cnt - 1'b1;
          end else begin
            pulse_q <= 1'b1;
            if (mode) begin
              cnt <= reload;
            end else begin
              state  <= ST_IDLE;
              cnt    <= '0;
              done_q <= 1'b1;
            end
          end
        end
      end
    end

    assign running[i]                        = (state == ST_RUN);
    assign done[i]                           = done_q;
    assign done_pulse[i]                     = pulse_q;
    assign remaining[i*DELAY_W +: DELAY_W]   = cnt;
  end

endmodule

// File: tb/tb_multi_delay_timer.sv
// tb/tb_multi_delay_timer.sv - self-checking bench for multi_delay_timer
module tb_multi_delay_timer;

  localparam int TP = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  start = '0, periodic = '0, abort = '0;
  logic [15:0] delay = '0;
  logic [1:0]  done, done_pulse;
  logic        busy;
  logic [15:0] remaining;

  int checks = 0;
  int errors = 0;

  multi_delay_timer #(.NUM_CH(2), .DELAY_W(8), .TICK_PERIOD(TP), .TICK_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .start      (start),
    .periodic   (periodic),
    .abort      (abort),
    .delay      (delay),
    .done       (done),
    .done_pulse (done_pulse),
    .busy       (busy),
    .remaining  (remaining)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic       en;
    logic [1:0] st, per, ab;
    logic [7:0] d0, d1;
    logic [1:0] e_done, e_pulse;
    logic       e_busy;
    logic [7:0] e_r0, e_r1;
  } vec_t;

  localparam logic [20:0] RESET_OBS = {2'b11, 2'b00, 1'b0, 16'h0000};

  function automatic logic [20:0] obs();
    return {done, done_pulse, busy, remaining};
  endfunction

  function automatic vec_t mk(logic en, logic [1:0] st, per, ab, logic [7:0] d0, d1,
                              logic [1:0] ed, ep, logic eb, logic [7:0] r0, r1);
    vec_t v;
    v = {en, st, per, ab, d0, d1, ed, ep, eb, r0, r1};
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    start = '0; abort = '0; periodic = '0; delay = '0;
  endtask

  // Called #1 after a rising edge; asserts and releases reset between edges.
  task automatic do_reset(input string name);
    idle_inputs();
    reset = 1'b1;
    #2;
    check(name, obs(), RESET_OBS);
    #2;
    reset = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pulse(input int ch, input int bound, output int n);
    n = -1;
    for (int k = 1; k <= bound; k++) begin
      step();
      if (done_pulse[ch]) begin
        n = k;
        break;
      end
    end
  endtask

  // Reference model: enabled-cycle counter for ticks, integer counts per channel.
  int          m_en_cycles;
  int          m_cnt[2], m_rel[2];
  bit          m_act[2], m_per[2];
  logic [1:0]  m_pulse;

  task automatic model_reset();
    m_en_cycles = 0;
    m_pulse = '0;
    for (int c = 0; c < 2; c++) begin
      m_cnt[c] = 0; m_rel[c] = 0; m_act[c] = 0; m_per[c] = 0;
    end
  endtask

  task automatic model_step(input logic en, input logic [1:0] st, per, ab, input logic [15:0] d);
    bit tk;
    int dv;
    tk = en && ((m_en_cycles % TP) == TP - 1);
    if (en) m_en_cycles++;
    for (int c = 0; c < 2; c++) begin
      dv = int'(d[c*8 +: 8]);
      m_pulse[c] = 1'b0;
      if (ab[c]) begin
        m_act[c] = 0; m_cnt[c] = 0;
      end else if (st[c]) begin
        if (dv == 0) begin
          m_act[c] = 0; m_cnt[c] = 0; m_pulse[c] = 1'b1;
        end else begin
          m_act[c] = 1; m_cnt[c] = dv; m_rel[c] = dv; m_per[c] = per[c];
        end
      end else if (m_act[c] && tk) begin
        if (m_cnt[c] == 1) begin
          m_pulse[c] = 1'b1;
          if (m_per[c]) m_cnt[c] = m_rel[c];
          else begin m_act[c] = 0; m_cnt[c] = 0; end
        end else begin
          m_cnt[c]--;
        end
      end
    end
  endtask

  function automatic logic [20:0] model_obs();
    return {~m_act[1], ~m_act[0], m_pulse, (m_act[0] | m_act[1]),
            m_cnt[1][7:0], m_cnt[0][7:0]};
  endfunction

  vec_t tv[17];
  int   n, n2, npulse;
  logic [7:0] r_frozen;
  bit   frozen;
  logic [1:0] r_st, r_per, r_ab;
  logic       r_en;
  logic [15:0] r_d;

  initial begin
    idle_inputs();
    step();
    do_reset("reset_no_clock");

    // Table: prescaler phase is 0 right after reset, so ticks land on edges 4, 8, 12, 16.
    tv[0]  = mk(1, 2'b01, 2'b00, 2'b00, 8'd2, 8'd0, 2'b10, 2'b00, 1, 8'd2, 8'd0);
    tv[1]  = mk(1, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 2'b10, 2'b00, 1, 8'd2, 8'd0);
    tv[2]  = mk(1, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 2'b10, 2'b00, 1, 8'd2, 8'd0);
    tv[3]  = mk(1, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 2'b10, 2'b00, 1, 8'd1, 8'd0);
    tv[4]  = mk(1, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 2'b10, 2'b00, 1, 8'd1, 8'd0);
    tv[5]  = mk(1, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 2'b10, 2'b00, 1, 8'd1, 8'd0);
    tv[6]  = mk(1, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 2'b10, 2'b00, 1, 8'd1, 8'd0);
    tv[7]  = mk(1, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 2'b11, 2'b01, 0, 8'd0, 8'd0);
    tv[8]  = mk(1, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 2'b11, 2'b00, 0, 8'd0, 8'd0);
    tv[9]  = mk(1, 2'b10, 2'b00, 2'b00, 8'd0, 8'd0, 2'b11, 2'b10, 0, 8'd0, 8'd0);
    tv[10] = mk(1, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 2'b11, 2'b00, 0, 8'd0, 8'd0);
    tv[11] = mk(1, 2'b10, 2'b10, 2'b00, 8'd0, 8'd1, 2'b01, 2'b00, 1, 8'd0, 8'd1);
    tv[12] = mk(1, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 2'b01, 2'b00, 1, 8'd0, 8'd1);
    tv[13] = mk(1, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 2'b01, 2'b00, 1, 8'd0, 8'd1);
    tv[14] = mk(1, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 2'b01, 2'b00, 1, 8'd0, 8'd1);
    tv[15] = mk(1, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 2'b01, 2'b10, 1, 8'd0, 8'd1);
    tv[16] = mk(1, 2'b00, 2'b00, 2'b10, 8'd0, 8'd0, 2'b11, 2'b00, 0, 8'd0, 8'd0);

    for (int i = 0; i < 17; i++) begin
      enable = tv[i].en; start = tv[i].st; periodic = tv[i].per; abort = tv[i].ab;
      delay = {tv[i].d1, tv[i].d0};
      step();
      check($sformatf("vec%0d", i), obs(),
            {tv[i].e_done, tv[i].e_pulse, tv[i].e_busy, tv[i].e_r1, tv[i].e_r0});
    end

    // One-shot delay 3 on ch0.
    do_reset("reset_t2");
    enable = 1'b1; start = 2'b01; delay = 16'd3;
    step();
    idle_inputs();
    wait_pulse(0, 20, n);
    checks++;
    if (!(n >= 9 && n <= 12)) begin
      errors++;
      $display("FAIL oneshot_latency actual=%0d expected=9..12", n);
    end
    check("oneshot_done", done[0], 1'b1);
    npulse = 0;
    for (int k = 0; k < 40; k++) begin step(); if (done_pulse[0]) npulse++; end
    check("oneshot_no_repeat", npulse, 0);

    // Periodic delay 2 on ch1, then abort.
    do_reset("reset_t3");
    enable = 1'b1; start = 2'b10; periodic = 2'b10; delay = 16'h0200;
    step();
    idle_inputs();
    wait_pulse(1, 12, n);
    wait_pulse(1, 12, n2);
    check("periodic_gap1", n2, 8);
    wait_pulse(1, 12, n2);
    check("periodic_gap2", n2, 8);
    abort = 2'b10;
    step();
    abort = '0;
    check("abort_done", {done[1], busy}, 2'b10);
    npulse = 0;
    for (int k = 0; k < 24; k++) begin step(); if (done_pulse[1]) npulse++; end
    check("abort_no_pulse", npulse, 0);

    // Zero delay on ch0.
    do_reset("reset_t4");
    enable = 1'b1; start = 2'b01; delay = 16'd0;
    step();
    idle_inputs();
    check("zero_delay_pulse", {done, done_pulse, busy}, {2'b11, 2'b01, 1'b0});
    step();
    check("zero_delay_after", {done_pulse, busy}, 3'b000);

    // Freeze with enable low, then restart mid-run.
    do_reset("reset_t5");
    enable = 1'b1; start = 2'b01; delay = 16'd5;
    step();
    idle_inputs();
    for (int k = 0; k < 6; k++) step();
    r_frozen = remaining[7:0];
    enable = 1'b0;
    frozen = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (remaining[7:0] !== r_frozen || done_pulse !== 2'b00) frozen = 1'b0;
    end
    check("freeze_hold", frozen, 1'b1);
    enable = 1'b1; start = 2'b01; delay = 16'd7;
    step();
    idle_inputs();
    check("restart_load", {done[0], remaining[7:0]}, {1'b0, 8'd7});
    wait_pulse(0, 40, n);
    checks++;
    if (!(n >= 25 && n <= 28)) begin
      errors++;
      $display("FAIL restart_expiry actual=%0d expected=25..28", n);
    end

    // Async reset mid-run, then start+abort together.
    enable = 1'b1; start = 2'b11; periodic = 2'b01; delay = {8'd3, 8'd9};
    step();
    idle_inputs();
    for (int k = 0; k < 5; k++) step();
    do_reset("reset_mid_run");
    enable = 1'b1; start = 2'b01; abort = 2'b01; delay = 16'd4;
    step();
    idle_inputs();
    check("start_abort", obs(), RESET_OBS);
    step();
    check("start_abort_next", obs(), RESET_OBS);

    // Randomized run against the reference model.
    do_reset("reset_rand");
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      r_en  = ($urandom % 10) != 0;
      r_st  = {($urandom % 8) == 0, ($urandom % 8) == 0};
      r_ab  = {($urandom % 24) == 0, ($urandom % 24) == 0};
      r_per = 2'($urandom);
      r_d   = {8'($urandom % 6), 8'($urandom % 6)};
      enable = r_en; start = r_st; abort = r_ab; periodic = r_per; delay = r_d;
      step();
      model_step(r_en, r_st, r_per, r_ab, r_d);
      check($sformatf("rand%0d", i), obs(), model_obs());
    end
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
